// File: rtl/fpdiv_sched.sv
// Round-robin scheduler that time-shares one fpdiv divider among NREQ requesters.
// Optional abort-on-timeout is enabled by defining FPDIV_SCHED_TIMEOUT_EN.
module fpdiv_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic [1:0]           rsp_exc,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  output logic                 div_reset,
  input  logic                 div_done,
  input  logic [31:0]          div_result,
  input  logic [1:0]           div_exc
);

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("fpdiv_sched: unsupported NREQ/IDW/TIMEOUT combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic             div_reset_q, div_reset_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_exc_q, rsp_exc_d;
  logic             busy_q, busy_d;
  logic             first_q, first_d;
`ifdef FPDIV_SCHED_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;

  // First valid requester at or above the pointer, wrapping at NREQ-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_q) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_exc_d   = rsp_exc_q;
    first_d     = first_q;
    req_ready   = '0;
`ifdef FPDIV_SCHED_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (gnt_found && !RESET) begin
          req_ready[gnt_idx] = 1'b1;
          div_a_d = req_a[{gnt_idx, 5'b0} +: 32];
          div_b_d = req_b[{gnt_idx, 5'b0} +: 32];
          gnt_d   = gnt_idx;
          rr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        first_d = 1'b1;
`ifdef FPDIV_SCHED_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // DONE seen in the first WAIT cycle may be left over from the previous op
        first_d = 1'b0;
        if (!first_q && div_done) begin
          rsp_data_d = div_result;
          rsp_exc_d  = div_exc;
          rsp_id_d   = gnt_q;
          state_d    = S_RESP;
`ifdef FPDIV_SCHED_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rsp_data_d    = 32'h7FC0_0000;
          rsp_exc_d     = 2'b11;
          rsp_id_d      = gnt_q;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    div_reset_d = (state_d != S_WAIT);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_reset_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
      busy_q      <= 1'b0;
      first_q     <= 1'b0;
`ifdef FPDIV_SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_reset_q <= div_reset_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exc_q   <= rsp_exc_d;
      busy_q      <= busy_d;
      first_q     <= first_d;
`ifdef FPDIV_SCHED_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_exc   = rsp_exc_q;
  assign busy      = busy_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_reset = div_reset_q;
`ifdef FPDIV_SCHED_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpdiv_sched.sv
// Directed bench for fpdiv_sched with a behavioural divider whose DONE latency is programmable.
module tb_fpdiv_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                CLOCK, RESET;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_data, div_a, div_b, div_result;
  logic [1:0]          rsp_exc, div_exc;
  logic                div_reset, div_done;

  int checks = 0;
  int failures = 0;

  fpdiv_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(63)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_exc(rsp_exc), .rsp_timeout(rsp_timeout), .busy(busy),
    .div_a(div_a), .div_b(div_b), .div_reset(div_reset),
    .div_done(div_done), .div_result(div_result), .div_exc(div_exc)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Divider model: DONE rises lat cycles after the RESET cycle, dropped whenever RESET is high
  int         lat = 30;
  bit         never_done = 1'b0;
  bit         stale_force = 1'b0;
  logic [7:0] m_cnt;
  logic [31:0] m_result;
  logic [1:0]  m_exc;

  always @(posedge CLOCK) begin
    if (div_reset) m_cnt <= 8'd0;
    else if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
  end
  assign div_done   = stale_force || (!never_done && !div_reset && (int'(m_cnt) >= lat - 1));
  assign div_result = m_result;
  assign div_exc    = m_exc;

  // Grant / response logger for the fairness run
  bit                mon_en = 1'b0;
  logic [NREQ-1:0]   grants[$];
  logic [IDW-1:0]    ids[$];
  always @(negedge CLOCK) begin
    if (mon_en) begin
      if (req_ready != '0) grants.push_back(req_ready);
      if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    stale_force = 1'b0;
    never_done = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_wait_expired", 32'd0, 32'd1);
  endtask

  int n;
  logic [31:0] held_data;

  initial begin
    RESET = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    m_result = '0;
    m_exc = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      req_a[32*k +: 32] = 32'h4000_0000 + 32'(k);
      req_b[32*k +: 32] = 32'h3F80_0000 + 32'(k);
    end
    req_a[31:0] = 32'h40C0_0000;
    req_b[31:0] = 32'h4000_0000;

    // Reset values, with a request pending while RESET is high
    tick();
    req_valid = 4'b1111;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_outputs", {27'd0, rsp_valid, busy, div_reset, rsp_timeout, 1'b0}, 32'h4);
    check("rst_rsp_fields", {26'd0, rsp_id, rsp_exc, 2'b00}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_div_a", div_a, 32'h0);
    check("rst_div_b", div_b, 32'h0);
    req_valid = '0;
    RESET = 1'b0;
    tick();

    // Single op: 6.0 / 2.0 = 3.0, divider latency 30
    lat = 30;
    m_result = 32'h4040_0000;
    m_exc = 2'b00;
    req_valid = 4'b0001;
    #1;
    check("single_req_ready", 32'(req_ready), 32'h1);
    check("single_div_reset_idle", 32'(div_reset), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("single_ready_drop", 32'(req_ready), 32'h0);
    check("single_launch_reset", 32'(div_reset), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_div_a", div_a, 32'h40C0_0000);
    check("single_div_b", div_b, 32'h4000_0000);
    tick();
    check("single_wait_reset", 32'(div_reset), 32'h0);
    wait_rsp(200, n);
    check("single_latency", 32'(n + 2), 32'd32);
    check("single_rsp_id", 32'(rsp_id), 32'h0);
    check("single_rsp_data", rsp_data, 32'h4040_0000);
    check("single_rsp_exc", 32'(rsp_exc), 32'h0);
    check("single_rsp_timeout", 32'(rsp_timeout), 32'h0);
    check("single_resp_div_a", div_a, 32'h40C0_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_after_hs", {30'd0, rsp_valid, busy}, 32'h0);

    // Fairness: all requesters valid, consumer always ready
    do_reset();
    lat = 3;
    m_result = 32'h1234_5678;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    mon_en = 1'b1;
    n = 0;
    while (grants.size() < 5 && n < 300) begin
      tick();
      n++;
    end
    mon_en = 1'b0;
    req_valid = '0;
    check("fair_grant_count", 32'(grants.size()), 32'd5);
    check("fair_g0", 32'(grants[0]), 32'h1);
    check("fair_g1", 32'(grants[1]), 32'h2);
    check("fair_g2", 32'(grants[2]), 32'h4);
    check("fair_g3", 32'(grants[3]), 32'h8);
    check("fair_g4", 32'(grants[4]), 32'h1);
    check("fair_rsp_ids", {24'd0, ids[0], ids[1], ids[2], ids[3]}, 32'h1B);

    // Backpressure: result for requester 2 held while the consumer stalls
    do_reset();
    lat = 5;
    m_result = 32'h3F80_0000;
    m_exc = 2'b01;
    req_valid = 4'b0100;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0011;
    check("bp_div_a", div_a, 32'h4000_0002);
    wait_rsp(100, n);
    held_data = rsp_data;
    check("bp_rsp_data", held_data, 32'h3F80_0000);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_hold_ctrl", {24'd0, rsp_valid, rsp_id, rsp_exc, req_ready != 4'b0, div_reset},
            {24'd0, 1'b1, 2'd2, 2'b01, 1'b0, 1'b1});
      check("bp_hold_data", rsp_data, 32'h3F80_0000);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_cycle_ready", 32'(req_ready), 32'h0);
    tick();
    rsp_ready = 1'b0;
    #1;
    check("bp_regrant_wrap", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    wait_rsp(100, n);
    check("bp_second_id", 32'(rsp_id), 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Stale DONE: pointer is now 1, requester 1 issues while DONE is still high
    lat = 10;
    m_exc = 2'b00;
    req_valid = 4'b0010;
    #1;
    check("stale_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    stale_force = 1'b1;
    m_result = 32'hDEAD_BEEF;
    tick();
    check("stale_first_wait", 32'(rsp_valid), 32'h0);
    tick();
    stale_force = 1'b0;
    m_result = 32'h4120_0000;
    check("stale_not_taken", 32'(rsp_valid), 32'h0);
    wait_rsp(100, n);
    check("stale_latency", 32'(n + 3), 32'd12);
    check("stale_rsp_data", rsp_data, 32'h4120_0000);
    check("stale_rsp_id", 32'(rsp_id), 32'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset in the middle of WAIT abandons the op and clears the pointer
    do_reset();
    lat = 50;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < 5; c++) tick();
    check("mid_in_wait", {30'd0, busy, div_reset}, 32'h2);
    RESET = 1'b1;
    tick();
    check("mid_rst_outputs", {28'd0, rsp_valid, busy, div_reset, rsp_timeout}, 32'h2);
    check("mid_rst_div_a", div_a, 32'h0);
    check("mid_rst_data", rsp_data, 32'h0);
    RESET = 1'b0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (rsp_valid) n++;
    end
    check("mid_no_rsp", 32'(n), 32'h0);
    req_valid = 4'b1111;
    #1;
    check("mid_ptr_zero", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    do_reset();

`ifdef FPDIV_SCHED_TIMEOUT_EN
    // Divider never finishes: abort after 63 WAIT cycles
    never_done = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_rsp(200, n);
    check("to_latency", 32'(n + 1), 32'd65);
    check("to_flag", 32'(rsp_timeout), 32'h1);
    check("to_exc", 32'(rsp_exc), 32'h3);
    check("to_data", rsp_data, 32'h7FC0_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    never_done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
